// File: rtl/debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
//
// Input conditioner for rotary-encoder pins. Each raw asynchronous pin
// passes through a two-flop synchronizer and then a saturating up/down
// integrator with hysteresis. The result is a clean level plus one-cycle edge
// pulses. An internal prescaler paces the integrator, so the debounce window
// scales with the clock rate.
//
// Parameters:
//   CHANNELS      number of independent input channels
//   PRESCALE      integrator sample period in clk cycles (>= 1)
//   STABLE_COUNT  integrator ceiling; net agreeing samples to flip an output
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   en     prescaler enable; low freezes sampling
//   din    raw asynchronous pins
//   dout   debounced levels
//   rise   one-cycle pulse when dout[i] goes 0->1
//   fall   one-cycle pulse when dout[i] goes 1->0
//   tick   integrator sample strobe
// ----------------------------------------------------------------------------
module debounce_sync #(
    parameter int CHANNELS     = 2,
    parameter int PRESCALE     = 1,
    parameter int STABLE_COUNT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE_COUNT + 1);

    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_COUNT);

    logic [CHANNELS-1:0]          s1;
    logic [CHANNELS-1:0]          s2;
    logic [PW-1:0]                pcnt;
    logic [CHANNELS-1:0][CW-1:0]  cnt;
    logic [CHANNELS-1:0][CW-1:0]  cnt_nxt;
    logic [CHANNELS-1:0]          dout_nxt;

    // Two-flop synchronizer; runs regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Sample prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
        end
    end

    assign tick = en && (pcnt == PMAX);

    // Saturating integrator and hysteresis decision, per channel.
    // The output moves only when the count reaches either rail, so any
    // intermediate count keeps the previous level.
    always_comb begin
        cnt_nxt  = cnt;
        dout_nxt = dout;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (s2[i] && (cnt[i] < CMAX)) begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end else if (!s2[i] && (cnt[i] != '0)) begin
                    cnt_nxt[i] = cnt[i] - 1'b1;
                end
                if (cnt_nxt[i] == CMAX) begin
                    dout_nxt[i] = 1'b1;
                end else if (cnt_nxt[i] == '0) begin
                    dout_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Pulses are registered alongside dout so they coincide with the first
    // cycle the new level is visible; reset clears all without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            dout <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            cnt  <= cnt_nxt;
            dout <= dout_nxt;
            rise <= dout_nxt & ~dout;
            fall <= ~dout_nxt & dout;
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// ----------------------------------------------------------------------------
// tb_debounce_sync
//
// Self-checking bench for debounce_sync. dut1 uses the defaults
// (CHANNELS=2, PRESCALE=1, STABLE_COUNT=4) and is driven from a vector table;
// dut2 uses PRESCALE=3, STABLE_COUNT=2 for the prescaler/enable sequence.
// Outputs are sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_debounce_sync;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, en1;
    logic [1:0] din1, dout1, rise1, fall1;
    logic       tick1;

    logic       rst2, en2;
    logic [1:0] din2, dout2, rise2, fall2;
    logic       tick2;

    debounce_sync dut1 (
        .clk   (clk),
        .reset (rst1),
        .en    (en1),
        .din   (din1),
        .dout  (dout1),
        .rise  (rise1),
        .fall  (fall1),
        .tick  (tick1)
    );

    debounce_sync #(
        .CHANNELS     (2),
        .PRESCALE     (3),
        .STABLE_COUNT (2)
    ) dut2 (
        .clk   (clk),
        .reset (rst2),
        .en    (en2),
        .din   (din2),
        .dout  (dout2),
        .rise  (rise2),
        .fall  (fall2),
        .tick  (tick2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] din;
        logic [1:0] dout;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       tick;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic r, input logic e, input logic [1:0] d,
                       input logic [1:0] xd, input logic [1:0] xr, input logic [1:0] xf,
                       input logic xt);
        vec_t v;
        v.rst = r; v.en = e; v.din = d;
        v.dout = xd; v.rise = xr; v.fall = xf; v.tick = xt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step1(input logic r, input logic e, input logic [1:0] d);
        rst1 = r; en1 = e; din1 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic r, input logic e, input logic [1:0] d);
        rst2 = r; en2 = e; din2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [1:0] xd, input logic [1:0] xr,
                        input logic [1:0] xf);
        chk({tag, " dout"}, 8'(dout1), 8'(xd));
        chk({tag, " rise"}, 8'(rise1), 8'(xr));
        chk({tag, " fall"}, 8'(fall1), 8'(xf));
    endtask

    task automatic chk2(input string tag, input logic [1:0] xd, input logic [1:0] xr,
                        input logic xt);
        chk({tag, " dout"}, 8'(dout2), 8'(xd));
        chk({tag, " rise"}, 8'(rise2), 8'(xr));
        chk({tag, " tick"}, 8'(tick2), 8'(xt));
    endtask

    initial begin
        rst1 = 1'b1; en1 = 1'b1; din1 = 2'b11;
        rst2 = 1'b1; en2 = 1'b1; din2 = 2'b00;

        // Reset held 3 cycles with din=11, then both channels rise on edge 6.
        add(3, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
        add(5, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2'b11, 2'b11, 2'b11, 2'b00, 1);
        add(1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1);
        // Both channels fall together six edges after din drops.
        add(5, 0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        // Glitch: 3 cycles high peaks at cnt=3, never reaches the ceiling.
        add(3, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(5, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        // Bounce 1,1,1,0,1,1 then held: cnt 1,2,3,2,3,4.
        add(3, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(3, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(1, 0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        // Hysteresis: 2 low cycles dip cnt to 2, level holds, cnt back to 4.
        add(2, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 1);
        add(4, 0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        // Sustained low: falls once cnt reaches 0.
        add(5, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);

        foreach (vecs[i]) begin
            step1(vecs[i].rst, vecs[i].en, vecs[i].din);
            chk($sformatf("vec%0d dout", i), 8'(dout1), 8'(vecs[i].dout));
            chk($sformatf("vec%0d rise", i), 8'(rise1), 8'(vecs[i].rise));
            chk($sformatf("vec%0d fall", i), 8'(fall1), 8'(vecs[i].fall));
            chk($sformatf("vec%0d tick", i), 8'(tick1), 8'(vecs[i].tick));
            chk($sformatf("vec%0d excl", i), 8'(rise1 & fall1), 8'h00);
        end

        // Reset mid-operation: clears dout without a fall pulse, then re-rises.
        for (int k = 1; k <= 5; k++) begin
            step1(1'b0, 1'b1, 2'b11);
            chk1($sformatf("mid pre e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step1(1'b0, 1'b1, 2'b11);
        chk1("mid pre e6", 2'b11, 2'b11, 2'b00);
        step1(1'b1, 1'b1, 2'b11);
        chk1("mid reset", 2'b00, 2'b00, 2'b00);
        for (int k = 1; k <= 5; k++) begin
            step1(1'b0, 1'b1, 2'b11);
            chk1($sformatf("mid post e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step1(1'b0, 1'b1, 2'b11);
        chk1("mid post e6", 2'b11, 2'b11, 2'b00);
        step1(1'b0, 1'b1, 2'b11);
        chk1("mid post e7", 2'b11, 2'b00, 2'b00);

        // Prescaler: dut2 has been in reset with en=1, so no tick.
        chk2("ps reset", 2'b00, 2'b00, 1'b0);
        // Step on din[1]; ticks after edges 2,5,...; integrator updates on edges 3,6,...
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps e1", 2'b00, 2'b00, 1'b0);
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps e2", 2'b00, 2'b00, 1'b1);
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps e3", 2'b00, 2'b00, 1'b0);
        // en low for 10 cycles with cnt=1: no ticks, nothing moves.
        for (int k = 0; k < 10; k++) begin
            step2(1'b0, 1'b0, 2'b10);
            chk2($sformatf("ps hold%0d", k), 2'b00, 2'b00, 1'b0);
        end
        // Resume from held phase pcnt=0: tick after 2 edges, rise on the 3rd.
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps r1", 2'b00, 2'b00, 1'b0);
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps r2", 2'b00, 2'b00, 1'b1);
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps r3", 2'b10, 2'b10, 1'b0);
        step2(1'b0, 1'b1, 2'b10);
        chk2("ps r4", 2'b10, 2'b00, 1'b0);
        chk("ps fall", 8'(fall2), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
